// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Reads the current PC, issues a read
//               to 1-cycle-latency synchronous instruction memory, captures
//               the returned word into an instruction register and hands it
//               to the decoder over a valid/ready handshake. Drives the PC
//               register's increment and load controls for sequential
//               advance and branch redirection.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic [PC_W-1:0]   pc_in,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_value,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd_data,
    input  logic              branch_req,
    input  logic [PC_W-1:0]   branch_target,
    output logic [DATA_W-1:0] ir_out,
    output logic [PC_W-1:0]   ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [15:0]       fetch_count,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_halted = 3'd4;

    // ------------------------------------------------------------------------
    // State and instruction register
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,       state_d;
    logic [DATA_W-1:0] ir_out_q,      ir_out_d;
    logic [PC_W-1:0]   ir_pc_q,       ir_pc_d;
    logic              ir_valid_q,    ir_valid_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    // Combinational helpers
    logic              w_active;
    logic              w_branch;
    logic              w_rd_en;
    logic              w_handshake;

    // Only the low ADDR_W bits of the PC address memory; the upper bits are
    // deliberately left unconnected here.
    generate
        if (PC_W > ADDR_W) begin : g_pc_hi
            logic w_unused_pc_hi;
            assign w_unused_pc_hi = ^pc_in[PC_W-1:ADDR_W];
        end
    endgenerate

    // Branches only matter while the pipeline is live; IDLE/HALTED ignore them.
    always_comb begin
        w_active    = (state_q == c_st_fetch) ||
                      (state_q == c_st_wait)  ||
                      (state_q == c_st_hold);
        w_branch    = w_active && branch_req;
        w_rd_en     = (state_q == c_st_fetch) && !branch_req;
        w_handshake = (state_q == c_st_hold) && ir_ready && !branch_req;
    end

    // PC control and memory interface; idle values are zero so nothing stale
    // leaks onto the buses.
    always_comb begin
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        imem_rd_en    = 1'b0;
        imem_addr     = '0;

        if (w_branch) begin
            // A redirect owns the PC port exclusively: no increment, no read.
            pc_load       = 1'b1;
            pc_load_value = branch_target;
        end else begin
            // Advance the PC in the cycle the read data returns, so the
            // captured ir_pc is still the pre-increment address.
            pc_inc = (state_q == c_st_wait);
        end

        if (w_rd_en) begin
            imem_rd_en = 1'b1;
            imem_addr  = pc_in[ADDR_W-1:0];
        end
    end

    // Next-state, instruction register capture and handshake accounting.
    always_comb begin
        state_d       = state_q;
        ir_out_d      = ir_out_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            c_st_idle: begin
                ir_valid_d = 1'b0;
                if (start) begin
                    state_d = halt ? c_st_halted : c_st_fetch;
                end
            end

            c_st_fetch: begin
                // Branch here just re-issues the fetch at the new PC.
                ir_valid_d = 1'b0;
                state_d    = c_st_wait;
                if (branch_req) begin
                    state_d = c_st_fetch;
                end
            end

            c_st_wait: begin
                if (branch_req) begin
                    // Returned word belongs to the wrong path: drop it.
                    ir_valid_d = 1'b0;
                    state_d    = c_st_fetch;
                end else begin
                    ir_out_d   = imem_rd_data;
                    ir_pc_d    = pc_in;
                    ir_valid_d = 1'b1;
                    state_d    = c_st_hold;
                end
            end

            c_st_hold: begin
                if (branch_req) begin
                    // Redirect wins over a simultaneous ready: no handshake.
                    ir_valid_d = 1'b0;
                    state_d    = c_st_fetch;
                end else if (w_handshake) begin
                    ir_valid_d    = 1'b0;
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = halt ? c_st_halted : c_st_fetch;
                end
            end

            c_st_halted: begin
                ir_valid_d = 1'b0;
                if (start && !halt) begin
                    state_d = c_st_fetch;
                end
            end

            default: begin
                ir_valid_d = 1'b0;
                state_d    = c_st_idle;
            end
        endcase
    end

    // Register update; reset discards any in-flight fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= c_st_idle;
            ir_out_q      <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            ir_out_q      <= ir_out_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Output mapping.
    always_comb begin
        ir_out      = ir_out_q;
        ir_pc       = ir_pc_q;
        ir_valid    = ir_valid_q;
        fetch_count = fetch_count_q;
        busy        = w_active;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. Surrounds the
//               DUT with a behavioural PC register and a 1-cycle-latency
//               instruction memory, then walks through hand-computed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int PC_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              halt;
    logic [PC_W-1:0]   pc_in;
    logic              pc_inc;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_value;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rd_data;
    logic              branch_req;
    logic [PC_W-1:0]   branch_target;
    logic [DATA_W-1:0] ir_out;
    logic [PC_W-1:0]   ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [15:0]       fetch_count;
    logic              busy;

    // Harness-side PC register and memory
    logic              pc_set;
    logic [PC_W-1:0]   pc_set_val;
    logic [DATA_W-1:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .halt          (halt),
        .pc_in         (pc_in),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rd_data  (imem_rd_data),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .ir_out        (ir_out),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .fetch_count   (fetch_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural reg_pc; the bench can force a value for corner cases.
    always @(posedge clk) begin
        if (pc_set)       pc_in <= pc_set_val;
        else if (reset)   pc_in <= '0;
        else if (pc_load) pc_in <= pc_load_value;
        else if (pc_inc)  pc_in <= pc_in + 16'd1;
    end

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("pc_excl", {31'd0, pc_inc & pc_load}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'hA001;
        mem[8'h01] = 16'hB002;
        mem[8'h40] = 16'hC040;
        mem[8'h80] = 16'hD080;
        mem[8'hFF] = 16'hE0FF;

        reset = 1'b1; start = 1'b0; halt = 1'b0; ir_ready = 1'b0;
        branch_req = 1'b0; branch_target = '0;
        pc_set = 1'b0; pc_set_val = '0; pc_in = '0; imem_rd_data = '0;

        // ---- Reset state
        tick(); tick();
        check("rst_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_ir", {16'd0, ir_out}, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rden", {31'd0, imem_rd_en}, 32'd0);

        // ---- Basic fetch, 3-cycle cadence
        reset = 1'b0; start = 1'b1; ir_ready = 1'b1;
        tick();                                  // FETCH
        start = 1'b0;
        check("f1_rden", {31'd0, imem_rd_en}, 32'd1);
        check("f1_addr", {24'd0, imem_addr}, 32'h00);
        check("f1_inc", {31'd0, pc_inc}, 32'd0);
        check("f1_busy", {31'd0, busy}, 32'd1);
        tick();                                  // WAIT
        check("w1_inc", {31'd0, pc_inc}, 32'd1);
        check("w1_rden", {31'd0, imem_rd_en}, 32'd0);
        check("w1_valid", {31'd0, ir_valid}, 32'd0);
        tick();                                  // HOLD
        check("h1_valid", {31'd0, ir_valid}, 32'd1);
        check("h1_ir", {16'd0, ir_out}, 32'hA001);
        check("h1_irpc", {16'd0, ir_pc}, 32'h0000);
        check("h1_count", {16'd0, fetch_count}, 32'd0);
        tick();                                  // FETCH
        check("f2_count", {16'd0, fetch_count}, 32'd1);
        check("f2_valid", {31'd0, ir_valid}, 32'd0);
        check("f2_rden", {31'd0, imem_rd_en}, 32'd1);
        check("f2_addr", {24'd0, imem_addr}, 32'h01);

        // ---- Back-pressure in HOLD
        ir_ready = 1'b0;
        tick();                                  // WAIT
        tick();                                  // HOLD
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, ir_valid}, 32'd1);
            check("bp_ir", {16'd0, ir_out}, 32'hB002);
            check("bp_irpc", {16'd0, ir_pc}, 32'h0001);
            check("bp_inc", {31'd0, pc_inc}, 32'd0);
            check("bp_rden", {31'd0, imem_rd_en}, 32'd0);
            tick();
        end
        ir_ready = 1'b1;
        tick();                                  // handshake -> FETCH
        check("bp_count", {16'd0, fetch_count}, 32'd2);
        check("bp_pc", {16'd0, pc_in}, 32'h0002);

        // ---- Branch in WAIT
        tick();                                  // WAIT
        branch_req = 1'b1; branch_target = 16'h0040;
        #1;
        check("bw_load", {31'd0, pc_load}, 32'd1);
        check("bw_val", {16'd0, pc_load_value}, 32'h0040);
        check("bw_inc", {31'd0, pc_inc}, 32'd0);
        tick();                                  // FETCH at 0x40
        branch_req = 1'b0; branch_target = '0;
        #1;
        check("bw_valid", {31'd0, ir_valid}, 32'd0);
        check("bw_ir_kept", {16'd0, ir_out}, 32'hB002);
        check("bw_addr", {24'd0, imem_addr}, 32'h40);
        check("bw_load_off", {16'd0, pc_load_value}, 32'h0000);
        tick();                                  // WAIT
        tick();                                  // HOLD
        check("bw_ir", {16'd0, ir_out}, 32'hC040);
        check("bw_irpc", {16'd0, ir_pc}, 32'h0040);
        check("bw_count", {16'd0, fetch_count}, 32'd2);

        // ---- Branch with ir_ready in HOLD
        branch_req = 1'b1; branch_target = 16'h0080;
        #1;
        check("bh_load", {31'd0, pc_load}, 32'd1);
        check("bh_val", {16'd0, pc_load_value}, 32'h0080);
        tick();                                  // FETCH at 0x80
        branch_req = 1'b0; branch_target = '0;
        #1;
        check("bh_valid", {31'd0, ir_valid}, 32'd0);
        check("bh_count", {16'd0, fetch_count}, 32'd2);
        check("bh_addr", {24'd0, imem_addr}, 32'h80);

        // ---- Halt at handshake, then resume
        tick();                                  // WAIT
        tick();                                  // HOLD
        check("hl_ir", {16'd0, ir_out}, 32'hD080);
        halt = 1'b1;
        tick();                                  // HALTED
        check("hl_busy", {31'd0, busy}, 32'd0);
        check("hl_valid", {31'd0, ir_valid}, 32'd0);
        check("hl_count", {16'd0, fetch_count}, 32'd3);
        tick();
        check("hl_rden", {31'd0, imem_rd_en}, 32'd0);
        check("hl_inc", {31'd0, pc_inc}, 32'd0);
        check("hl_busy2", {31'd0, busy}, 32'd0);
        start = 1'b1; halt = 1'b0;
        tick();                                  // FETCH at 0x81
        start = 1'b0;
        check("rs_rden", {31'd0, imem_rd_en}, 32'd1);
        check("rs_addr", {24'd0, imem_addr}, 32'h81);

        // ---- PC wrap at 0xFFFF
        reset = 1'b1;
        tick();
        reset = 1'b0; pc_set = 1'b1; pc_set_val = 16'hFFFF; start = 1'b1;
        tick();                                  // FETCH at 0xFFFF
        pc_set = 1'b0; start = 1'b0;
        #1;
        check("wr_addr", {24'd0, imem_addr}, 32'hFF);
        check("wr_count0", {16'd0, fetch_count}, 32'd0);
        tick();                                  // WAIT
        check("wr_inc", {31'd0, pc_inc}, 32'd1);
        tick();                                  // HOLD
        check("wr_irpc", {16'd0, ir_pc}, 32'hFFFF);
        check("wr_ir", {16'd0, ir_out}, 32'hE0FF);
        check("wr_pc", {16'd0, pc_in}, 32'h0000);
        tick();                                  // FETCH at 0x0000
        check("wr_count", {16'd0, fetch_count}, 32'd1);

        // ---- Reset while in WAIT
        tick();                                  // WAIT
        reset = 1'b1;
        tick();                                  // IDLE
        check("rw_valid", {31'd0, ir_valid}, 32'd0);
        check("rw_count", {16'd0, fetch_count}, 32'd0);
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_ir", {16'd0, ir_out}, 32'd0);
        reset = 1'b0;
        tick();
        check("rw_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage sitting between the program counter register (reg_pc) and the instruction decoder. It reads the current PC and issues a read to synchronous instruction memory (1-cycle read latency). It latches the returned word into an instruction register and presents it downstream with a valid/ready handshake. It drives reg_pc's inc and load_enable/data_in controls, which handle sequential advance and branch redirection.

Parameters:
ADDR_W, 8, instruction memory address width; imem_addr = pc_in[ADDR_W-1:0]
DATA_W, 16, instruction word width
PC_W, 16, program counter width (matches reg_pc)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level; leaves IDLE/HALTED
halt  input  1  level; stops fetching at next instruction boundary
pc_in  input  PC_W  current PC (reg_pc data_out)
pc_inc  output  1  increment request to reg_pc
pc_load  output  1  load request to reg_pc (load_enable)
pc_load_value  output  PC_W  value to load (reg_pc data_in)
imem_rd_en  output  1  instruction memory read strobe
imem_addr  output  ADDR_W  instruction memory address
imem_rd_data  input  DATA_W  read data, valid the cycle after imem_rd_en
branch_req  input  1  redirect request from execute
branch_target  input  PC_W  redirect PC
ir_out  output  DATA_W  latched instruction
ir_pc  output  PC_W  PC of ir_out
ir_valid  output  1  ir_out valid
ir_ready  input  1  decoder accepts ir_out
fetch_count  output  16  number of completed ir handshakes, wraps 0xFFFF->0
busy  output  1  high in FETCH, WAIT and HOLD

Behaviour:
- Reset, checked every edge and highest priority: state=IDLE; ir_out=0, ir_pc=0, ir_valid=0, fetch_count=0. Reset mid-fetch discards all in-flight data.
- pc_inc, pc_load, pc_load_value, imem_rd_en and imem_addr are combinational from state and inputs. When not asserted: pc_load_value=0 and imem_addr=0.
- States and transitions:
  - IDLE: outputs idle. If start=1 and halt=0, go to FETCH. If start=1 and halt=1, go to HALTED.
  - FETCH: imem_rd_en=1, imem_addr=pc_in[ADDR_W-1:0]. Go to WAIT.
  - WAIT: imem_rd_data is valid. pc_inc=1 for this single cycle. At the edge, ir_out<=imem_rd_data, ir_pc<=pc_in (pre-increment value), ir_valid<=1. Go to HOLD.
  - HOLD: ir_valid=1 and ir_out/ir_pc are held stable. If ir_ready=1, the handshake completes at the edge: ir_valid<=0, fetch_count+1, then go to HALTED if halt=1, else FETCH. If ir_ready=0, stay in HOLD.
  - HALTED: ir_valid=0, no memory/PC activity. If start=1 and halt=0, go to FETCH.
- Branch, in FETCH/WAIT/HOLD only (ignored in IDLE/HALTED):
  - Same cycle: pc_load=1, pc_load_value=branch_target, pc_inc forced to 0, imem_rd_en forced to 0.
  - At the edge: ir_valid<=0, in-flight read data is discarded, go to FETCH.
  - A branch in HOLD overrides a simultaneous ir_ready: no handshake, fetch_count unchanged.
  - Branch beats halt; halt is re-evaluated at the next handshake.
- pc_inc and pc_load are never both 1.
- Throughput: 3 cycles per instruction with ir_ready held high (FETCH, WAIT, HOLD).
- PC wrap: pc_in=0xFFFF is fetched normally and reg_pc wraps to 0x0000. imem_addr uses the low ADDR_W bits only.
- halt sampled in FETCH or WAIT has no effect; it acts only at the HOLD handshake or on entry from IDLE.

Test Plan:
- Reset, then start=1 with pc_in=0x0000, mem[0]=0xA001, ir_ready=1 -> imem_rd_en in cycle 1, pc_inc in cycle 2, ir_valid with ir_out=0xA001 and ir_pc=0x0000 in cycle 3, fetch_count=1 after cycle 3, next FETCH in cycle 4.
- Back-pressure: ir_ready=0 for 5 cycles in HOLD -> ir_valid/ir_out stable, no pc_inc, no imem_rd_en. Raise ir_ready -> one handshake, fetch_count +1 exactly.
- Branch in WAIT with branch_target=0x0040 -> pc_load=1 with value 0x0040, pc_inc=0, returned word discarded. Next FETCH uses pc_in=0x0040 and ir_pc=0x0040.
- Branch and ir_ready both high in HOLD -> no handshake, fetch_count unchanged, ir_valid drops, pc_load=1.
- halt=1 during HOLD handshake -> HALTED, busy=0, no further reads. Then start=1, halt=0 -> fetch resumes at current pc_in.
- pc_in=0xFFFF with ADDR_W=8 -> imem_addr=0xFF, ir_pc=0xFFFF. reset asserted in WAIT -> next cycle IDLE, ir_valid=0, fetch_count=0.
